data_mem_responder: RTL

//  Data-memory target for the pipeline's MEM-stage port (mem_addr, mem_write_data, ram_write, write_type -> mem_read_data).

---
 rtl/data_mem_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_responder                                              |
// | Purpose  : Data-memory target for the pipeline MEM-stage port. Loads return|
// |            the aligned 32-bit word (extension stays in the core). SB/SH/SW |
// |            stores go through a one-entry store buffer with read-after-     |
// |            write bypass. Misaligned or undefined stores are dropped and    |
// |            counted as faults.                                              |
// | Ports    : clk, rst (async, active-high)                                   |
// |            mem_addr[31:0], ram_write, write_type[2:0], mem_write_data[31:0]|
// |            mem_read_data[31:0] (combinational)                             |
// |            store_fault (1-cycle pulse), fault_count[7:0] (saturating)      |
// |            tohost[31:0], halt (only with DMEM_TOHOST_EN)                   |
// | Options  : DMEM_TOHOST_EN - adds the tohost register and sticky halt flag  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int          AW          = 10,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        ram_write,
  input  logic [2:0]  write_type,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        store_fault,
  output logic [7:0]  fault_count
`ifdef DMEM_TOHOST_EN
  ,
  output logic [31:0] tohost,
  output logic        halt
`endif
);

  localparam int DEPTH = 2**AW;

  localparam logic [2:0] WT_SB = 3'b000;
  localparam logic [2:0] WT_SH = 3'b001;
  localparam logic [2:0] WT_SW = 3'b010;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] widx;
  logic [1:0]    lane;

  logic          st_legal;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic          tohost_word;
  logic          st_capture;

  logic          sb_valid_q, sb_valid_d;
  logic [AW-1:0] sb_idx_q,   sb_idx_d;
  logic [3:0]    sb_mask_q,  sb_mask_d;
  logic [31:0]   sb_data_q,  sb_data_d;

  logic          store_fault_q, store_fault_d;
  logic [7:0]    fault_count_q, fault_count_d;

  logic [31:0]   rd_data;

  // Address bits above the array are deliberately ignored (addresses wrap).
  logic          unused_ok;
  assign unused_ok = ^{mem_addr[31:AW+2], TOHOST_ADDR};

  assign widx = mem_addr[AW+1:2];
  assign lane = mem_addr[1:0];

`ifdef DMEM_TOHOST_EN
  // Full-address word match: tohost is not aliased into the wrapped array.
  assign tohost_word = (mem_addr[31:2] == TOHOST_ADDR[31:2]);
`else
  assign tohost_word = 1'b0;
`endif

  // Store decode: byte mask and lane-replicated data.
  always_comb begin
    st_legal = 1'b0;
    st_mask  = 4'h0;
    st_data  = mem_write_data;
    case (write_type)
      WT_SB: begin
        st_legal = 1'b1;
        st_mask  = 4'b0001 << lane;
        st_data  = {4{mem_write_data[7:0]}};
      end
      WT_SH: begin
        st_legal = ~lane[0];
        st_mask  = 4'b0011 << lane;
        st_data  = {2{mem_write_data[15:0]}};
      end
      WT_SW: begin
        st_legal = (lane == 2'b00);
        st_mask  = 4'hF;
      end
      default: st_legal = 1'b0;
    endcase
    // Only a full-word store may touch the tohost word.
    if (tohost_word && (write_type != WT_SW)) begin
      st_legal = 1'b0;
    end
  end

  assign st_capture = ram_write && st_legal && !tohost_word;

  // Buffer next state: a new legal store replaces the entry (the old entry
  // drains on the same edge), otherwise the entry empties after draining.
  always_comb begin
    sb_valid_d    = st_capture;
    sb_idx_d      = sb_idx_q;
    sb_mask_d     = sb_mask_q;
    sb_data_d     = sb_data_q;
    store_fault_d = ram_write && !st_legal;
    fault_count_d = fault_count_q;
    if (st_capture) begin
      sb_idx_d  = widx;
      sb_mask_d = st_mask;
      sb_data_d = st_data;
    end
    if (store_fault_d && (fault_count_q != 8'hFF)) begin
      fault_count_d = fault_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_q    <= 1'b0;
      sb_idx_q      <= '0;
      sb_mask_q     <= 4'h0;
      sb_data_q     <= 32'h0;
      store_fault_q <= 1'b0;
      fault_count_q <= 8'h00;
    end else begin
      sb_valid_q    <= sb_valid_d;
      sb_idx_q      <= sb_idx_d;
      sb_mask_q     <= sb_mask_d;
      sb_data_q     <= sb_data_d;
      store_fault_q <= store_fault_d;
      fault_count_q <= fault_count_d;
    end
  end

  // Array drain: one byte enable per lane, no reset on the storage.
  always_ff @(posedge clk) begin
    if (sb_valid_q) begin
      for (int i = 0; i < 4; i++) begin
        if (sb_mask_q[i]) begin
          mem[sb_idx_q][8*i +: 8] <= sb_data_q[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_TOHOST_EN
  logic [31:0] tohost_q, tohost_d;
  logic        halt_q,   halt_d;

  always_comb begin
    tohost_d = tohost_q;
    halt_d   = halt_q;
    if (ram_write && st_legal && tohost_word) begin
      tohost_d = mem_write_data;
      if (mem_write_data != 32'h0) begin
        halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_q <= 32'h0;
      halt_q   <= 1'b0;
    end else begin
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
    end
  end

  assign tohost = tohost_q;
  assign halt   = halt_q;
`endif

  // Read path: array word with buffered bytes overlaid per lane.
  always_comb begin
    rd_data = mem[widx];
    for (int i = 0; i < 4; i++) begin
      if (sb_valid_q && (sb_idx_q == widx) && sb_mask_q[i]) begin
        rd_data[8*i +: 8] = sb_data_q[8*i +: 8];
      end
    end
`ifdef DMEM_TOHOST_EN
    if (tohost_word) begin
      rd_data = tohost_q;
    end
`endif
  end

  assign mem_read_data = rd_data;
  assign store_fault   = store_fault_q;
  assign fault_count   = fault_count_q;

endmodule
`default_nettype wire
